// File: rtl/sysarr_stream.sv
// N x N output-stationary integer systolic array with internal operand skew,
// ready/valid beat input, drain sequencing and a one-cycle completion pulse.
module sysarr_stream #(
    parameter int N    = 4,
    parameter int DW   = 16,
    parameter int ACCW = 40
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [N*DW-1:0]       a_col,
    input  logic [N*DW-1:0]       b_row,
    input  logic                  acc_mode,
    input  logic                  signed_mode,
    output logic [N*N*ACCW-1:0]   res,
    output logic                  res_valid,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    localparam int CW = $clog2(2 * N);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(2 * N - 2);

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic            sgn_q;
    logic            accept;
    logic            first;
    logic            clr;

    logic [DW-1:0]   a_edge [N];
    logic [DW-1:0]   b_edge [N];
    logic [DW-1:0]   a_w    [N][N];
    logic [DW-1:0]   b_w    [N][N];

    // Product widened to ACCW; sign or zero extension follows the job's mode.
    function automatic logic [ACCW-1:0] mac_prod(input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b,
                                                 input logic          sgn);
        logic signed [DW:0]         ax;
        logic signed [DW:0]         bx;
        logic signed [2*DW+1:0]     p;
        logic [2*DW-1:0]            p2;
        logic [ACCW+2*DW-1:0]       ext;
        ax  = {sgn & a[DW-1], a};
        bx  = {sgn & b[DW-1], b};
        p   = ax * bx;
        p2  = p[2*DW-1:0];
        ext = {{ACCW{sgn & p2[2*DW-1]}}, p2};
        return ext[ACCW-1:0];
    endfunction

    assign in_ready = (state == IDLE) || (state == LOAD);
    assign accept   = in_valid && in_ready;
    assign first    = accept && (state == IDLE);
    assign clr      = first && !acc_mode;
    assign busy     = (state != IDLE) || res_valid;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = in_last ? DRAIN : LOAD;
            LOAD:    if (accept && in_last) state_nx = DRAIN;
            DRAIN:   if (cnt == DRAIN_LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sgn_q     <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= (state == DRAIN) ? cnt + CW'(1) : '0;
            res_valid <= (state == DONE);
            if (first) sgn_q <= signed_mode;
        end
    end

    // Skew chains: row i / column j get an input register plus i / j delays.
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        logic [DW-1:0] sa [gi+1];
        logic [DW-1:0] sb [gi+1];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int d = 0; d <= gi; d++) begin
                    sa[d] <= '0;
                    sb[d] <= '0;
                end
            end else begin
                sa[0] <= accept ? a_col[gi*DW +: DW] : '0;
                sb[0] <= accept ? b_row[gi*DW +: DW] : '0;
                for (int d = 1; d <= gi; d++) begin
                    sa[d] <= sa[d-1];
                    sb[d] <= sb[d-1];
                end
            end
        end

        assign a_edge[gi] = sa[gi];
        assign b_edge[gi] = sb[gi];
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DW-1:0]   a_in;
            logic [DW-1:0]   b_in;
            logic [DW-1:0]   ar;
            logic [DW-1:0]   br;
            logic [ACCW-1:0] ac;

            if (j == 0) begin : g_aw
                assign a_in = a_edge[i];
            end else begin : g_ai
                assign a_in = a_w[i][j-1];
            end

            if (i == 0) begin : g_bn
                assign b_in = b_edge[j];
            end else begin : g_bi
                assign b_in = b_w[i-1][j];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    ar <= '0;
                    br <= '0;
                    ac <= '0;
                end else begin
                    ar <= a_in;
                    br <= b_in;
                    if (clr) ac <= '0;
                    else     ac <= ac + mac_prod(a_in, b_in, sgn_q);
                end
            end

            assign a_w[i][j] = ar;
            assign b_w[i][j] = br;
            assign res[(i*N+j)*ACCW +: ACCW] = ac;
        end
    end

endmodule

// File: tb/tb_sysarr_stream.sv
// Directed bench for sysarr_stream: reset, identity, ones, sign modes,
// accumulation, bubbles/backpressure and mid-job reset.
module tb_sysarr_stream;

    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int ACCW = 40;
    localparam int RW   = N * N * ACCW;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [N*DW-1:0]   a_col;
    logic [N*DW-1:0]   b_row;
    logic              acc_mode;
    logic              signed_mode;
    logic [RW-1:0]     res;
    logic              res_valid;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    int lat;
    int pulses;
    int busy_pulse;
    int busy_after;
    int ready_bad;

    sysarr_stream #(.N(N), .DW(DW), .ACCW(ACCW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .a_col      (a_col),
        .b_row      (b_row),
        .acc_mode   (acc_mode),
        .signed_mode(signed_mode),
        .res        (res),
        .res_valid  (res_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] fill(input logic [ACCW-1:0] v);
        logic [RW-1:0] r;
        for (int e = 0; e < N * N; e++) r[e*ACCW +: ACCW] = v;
        return r;
    endfunction

    function automatic logic [RW-1:0] ident();
        logic [RW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[(i*N+i)*ACCW +: ACCW] = ACCW'(1);
        return r;
    endfunction

    function automatic logic [N*DW-1:0] vec_fill(input logic [DW-1:0] v);
        logic [N*DW-1:0] r;
        for (int e = 0; e < N; e++) r[e*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [N*DW-1:0] unit_vec(input int k);
        logic [N*DW-1:0] r;
        r = '0;
        r[k*DW +: DW] = DW'(1);
        return r;
    endfunction

    // pat: 0 = ones, 1 = identity (e_k on beat k), 2 = a=0xFFFD b=2.
    // gap: beat index after which three idle cycles are inserted (-1 none).
    // junk: drive garbage beats during the first drain cycles.
    task automatic run_job(input int nb, input int pat, input logic am,
                           input logic sm, input int gap, input logic junk);
        for (int k = 0; k < nb; k++) begin
            in_valid    = 1'b1;
            in_last     = (k == nb - 1);
            acc_mode    = (k == 0) ? am : ~am;
            signed_mode = (k == 0) ? sm : ~sm;
            case (pat)
                1:       begin a_col = unit_vec(k); b_row = unit_vec(k); end
                2:       begin a_col = vec_fill(16'hFFFD); b_row = vec_fill(16'd2); end
                default: begin a_col = vec_fill(16'd1); b_row = vec_fill(16'd1); end
            endcase
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (k == gap) repeat (3) begin @(posedge clk); #1; end
        end
        lat = -1; pulses = 0; busy_pulse = -1; busy_after = -1; ready_bad = 0;
        for (int c = 1; c <= 12; c++) begin
            if (junk && c <= 5) begin
                in_valid = 1'b1; in_last = 1'b1;
                a_col = vec_fill(16'd7); b_row = vec_fill(16'd9);
                if (in_ready !== 1'b0) ready_bad++;
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            @(posedge clk); #1;
            if (res_valid === 1'b1) begin
                pulses++;
                if (lat < 0) begin lat = c; busy_pulse = busy; end
            end
            if (lat > 0 && c == lat + 1) busy_after = busy;
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        checks++; if (res !== '0) begin failures++; $display("FAIL reset_res got=%h exp=0", res); end
    endtask

    task automatic test_identity(input string tag);
        run_job(4, 1, 1'b0, 1'b1, -1, 1'b0);
        checks++; if (res !== ident()) begin failures++; $display("FAIL %s_res got=%h exp=%h", tag, res, ident()); end
        checks++; if (lat != 2 * N) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", tag, lat, 2 * N); end
        checks++; if (pulses != 1) begin failures++; $display("FAIL %s_pulses got=%0d exp=1", tag, pulses); end
    endtask

    task automatic test_all_ones();
        run_job(4, 0, 1'b0, 1'b0, -1, 1'b0);
        checks++; if (res !== fill(ACCW'(4))) begin failures++; $display("FAIL ones_res got=%h exp=%h", res, fill(ACCW'(4))); end
        checks++; if (busy_pulse != 1) begin failures++; $display("FAIL ones_busy_at_pulse got=%0d exp=1", busy_pulse); end
        checks++; if (busy_after != 0) begin failures++; $display("FAIL ones_busy_after got=%0d exp=0", busy_after); end
    endtask

    task automatic test_sign();
        logic [ACCW-1:0] neg24;
        neg24 = ACCW'(-24);
        run_job(4, 2, 1'b0, 1'b1, -1, 1'b0);
        checks++; if (res !== fill(neg24)) begin failures++; $display("FAIL sign_signed got=%h exp=%h", res[ACCW-1:0], neg24); end
        run_job(4, 2, 1'b0, 1'b0, -1, 1'b0);
        checks++; if (res !== fill(ACCW'(524264))) begin failures++; $display("FAIL sign_unsigned got=%0d exp=524264", res[ACCW-1:0]); end
    endtask

    task automatic test_accumulate();
        run_job(4, 0, 1'b0, 1'b0, -1, 1'b0);
        run_job(2, 0, 1'b1, 1'b0, -1, 1'b0);
        checks++; if (res !== fill(ACCW'(6))) begin failures++; $display("FAIL accum_6 got=%0d exp=6", res[ACCW-1:0]); end
        run_job(1, 0, 1'b0, 1'b0, -1, 1'b0);
        checks++; if (res !== fill(ACCW'(1))) begin failures++; $display("FAIL accum_clear got=%0d exp=1", res[ACCW-1:0]); end
        checks++; if (lat != 2 * N) begin failures++; $display("FAIL single_beat_latency got=%0d exp=%0d", lat, 2 * N); end
    endtask

    task automatic test_bubbles();
        run_job(4, 0, 1'b0, 1'b0, 1, 1'b1);
        checks++; if (res !== fill(ACCW'(4))) begin failures++; $display("FAIL bubble_res got=%0d exp=4", res[ACCW-1:0]); end
        checks++; if (ready_bad != 0) begin failures++; $display("FAIL drain_ready got=%0d_high exp=0_high", ready_bad); end
        checks++; if (pulses != 1) begin failures++; $display("FAIL bubble_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_reset_mid();
        int seen;
        acc_mode = 1'b0; signed_mode = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_last = 1'b0;
            a_col = vec_fill(16'd3); b_row = vec_fill(16'd5);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (res !== '0) begin failures++; $display("FAIL midrst_res got=%h exp=0", res); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (res_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL midrst_no_pulse got=%0d exp=0", seen); end
        test_identity("post_rst_identity");
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        a_col = '0; b_row = '0; acc_mode = 1'b0; signed_mode = 1'b0;
        #1;
        test_reset();
        test_identity("identity");
        test_all_ones();
        test_sign();
        test_accumulate();
        test_bubbles();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sysarr_stream.md
# sysarr_stream

Parametrised N×N output-stationary integer systolic array with built-in input skew, a ready/valid beat interface and a job controller. It is the successor to the fixed 4×4 array, where the caller had to pre-skew operands and count drain cycles by hand. The block accepts one column of A and one row of B per beat and skews, drains and flags completion internally. It sits between the operand fetch logic and the result writeback in the accelerator datapath.

## Interface
Parameters:
- N, 4, array dimension; N ≥ 2.
- DW, 16, operand element width.
- ACCW, 40, accumulator width; must be ≥ 2·DW.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat ready. A beat transfers on a rising edge with in_valid && in_ready.
- in_last  in  1  marks the final beat of a job.
- a_col  in  N·DW  column k of A; element i is at bits [i·DW +: DW].
- b_row  in  N·DW  row k of B; element j is at bits [j·DW +: DW].
- acc_mode  in  1  sampled on the first beat of a job. 0 clears all accumulators; 1 accumulates onto the existing results.
- signed_mode  in  1  sampled on the first beat of a job. 1 treats operands as two's complement; 0 treats them as unsigned.
- res  out  N·N·ACCW  accumulator (i,j) is at bits [(i·N+j)·ACCW +: ACCW].
- res_valid  out  1  one-cycle pulse when the job's results are final.
- busy  out  1  high from first-beat acceptance until the res_valid cycle, inclusive.

## Operation
FSM states and transitions:
- IDLE → LOAD on the first accepted beat. If that beat also has in_last, go directly to DRAIN.
- LOAD → DRAIN on an accepted beat with in_last.
- DRAIN lasts 2N−1 cycles, then moves to DONE.
- DONE lasts one cycle, then returns to IDLE.

Other state rules:
- in_ready = 1 in IDLE and LOAD, 0 in DRAIN and DONE.
- Beats presented while in_ready = 0 are ignored.

Skew and data flow:
- Element a_i passes through i delay registers before PE(i,0).
- Element b_j passes through j delay registers before PE(0,j).
- Each PE registers a and forwards it right, registers b and forwards it down, and performs acc += a·b.
- In any cycle with no accepted beat (a bubble in LOAD, or any DRAIN cycle), zeros enter the skew chains. Bubbles therefore do not change the result.

Arithmetic:
- The product is 2·DW bits, sign- or zero-extended per the latched signed_mode, then extended to ACCW.
- Accumulation wraps modulo 2^ACCW; there is no saturation.

Mode latching and result hold:
- acc_mode and signed_mode are latched on the first beat and held for the whole job. Changes mid-job have no effect.
- With acc_mode = 0, all accumulators are zeroed on the edge that accepts the first beat. No products from the previous job are in flight at that point.
- res is driven combinationally from the accumulators. It is stable from res_valid until the edge that accepts the next job's first beat.

Reset:
- Reset values: FSM IDLE, all accumulators and skew/PE registers 0, res = 0, res_valid = 0, busy = 0, in_ready = 1 in the cycle after rst.
- rst asserted mid-job (LOAD, DRAIN or DONE) aborts the job: no res_valid, and state is as after reset.

## Timing
- The beat accepted at edge t_k is multiplied in PE(i,j) on edge t_k + 1 + i + j.
- With the last beat accepted at edge t_L:
  - the final MAC is at t_L + 2N − 1;
  - res_valid is high during the cycle after edge t_L + 2N;
  - the earliest next beat is accepted at t_L + 2N + 1.
- A single-beat job (in_valid && in_last on the first beat) follows the same timing.
- Throughput: one beat per cycle in LOAD. Job overhead is 2N cycles.

## Test plan
- Identity: N=4, DW=16, signed. 4 beats, with beat k having a_col = b_row = e_k. Required: res = I (diagonal 1, others 0), and res_valid exactly 8 cycles after the last-beat edge.
- All ones: 4 beats of ones with acc_mode = 0. Required: every res element = 4; busy falls with res_valid.
- Sign handling: 4 beats with a = 0xFFFD, b = 2. Signed mode gives every element = −24 (ACCW bits, two's complement). Unsigned mode gives every element = 524264.
- Accumulate: a job of 4 ones-beats with acc_mode = 0, then a job of 2 ones-beats with acc_mode = 1. Required: every element = 6. A third job of 1 ones-beat with acc_mode = 0 gives every element = 1.
- Bubbles and backpressure: the all-ones job with in_valid low for 3 cycles between beats 2 and 3 gives every element = 4. Beats driven during DRAIN see in_ready = 0 and do not alter res.
- Reset mid-LOAD: assert rst after beat 2. Required: res = 0, busy = 0, and no res_valid pulse. The next identity job then gives res = I.
